mei_ctrl: RTL
=============

// Module: mei_ctrl
// PURPOSE
//  Platform-side external-interrupt controller; drives the core CSR block's machine-external-interrupt inputs.
//  Per source: synchronises a raw async line, detects a level or a rising edge, and latches a pending request.
//  Software claims and completes interrupts over a simple register port.
//  Output vector o_MEI[k] is wired to the CSR block's i_MEI_k (k = 0..5).
// PARAMETERS
//  N_SRC        6   number of interrupt sources (CSR block consumes exactly 6)
//  SYNC_STAGES  2   flop stages in each input synchroniser (>=2)
// PORTS
//  i_CLK      in   1      core clock; all logic on rising edge
//  i_RSTn     in   1      reset, asynchronous, active-low
//  i_IRQ_SRC  in   N_SRC  raw asynchronous interrupt lines, active-high
//  i_WE       in   1      register write strobe
//  i_RE       in   1      register read strobe
//  i_ADDR     in   4      register word index
//  i_WDATA    in   32     write data
//  o_RDATA    out  32     read data, registered
//  o_MEI      out  N_SRC  per-source request to the CSR block: (state==PENDING) & ENABLE[k]
// BEHAVIOUR
//  Reset: all state flops, synchronisers, ENABLE, EDGE and o_RDATA go to 0. Every source enters IDLE. o_MEI = 0.
//  Registers:
//   0x0 PENDING  RO  bit k = 1 when source k is PENDING
//   0x1 ENABLE   RW
//   0x2 EDGE     RW  1 = rising-edge trigger, 0 = level trigger
//   0x3 CLAIM    RO  lowest-index enabled PENDING source id+1, or 0 if none
//   0x4 COMPLETE WO  write id+1
//   other addresses read 0; writes to them are ignored
//  Trigger:
//   level mode: trigger = synchronised line high
//   edge mode:  trigger = synchronised line 1 and previous synchronised value 0
//  Per-source FSM:
//   IDLE -> PENDING on trigger
//   PENDING -> IN_SERVICE when a CLAIM read returns this id
//   IN_SERVICE -> IDLE on COMPLETE with this id
//    - if REARM is set or the trigger is active that cycle, go to PENDING instead.
//   REARM is an edge seen while PENDING or IN_SERVICE. It is cleared on entry to PENDING.
//  Latency:
//   raw line stable high -> o_MEI high after SYNC_STAGES+1 clock edges (source enabled).
//   o_RDATA is valid on the edge after the i_RE cycle and holds until the next read.
//   CLAIM side effect is applied on the same edge.
//  Boundaries:
//   - i_WE and i_RE in the same cycle: the write executes, the read is dropped and o_RDATA holds its value.
//   - CLAIM with nothing pending returns 0 and changes no state.
//   - COMPLETE with id 0, id > N_SRC, or a source not IN_SERVICE is ignored.
//   - Disabling a PENDING source keeps it PENDING but masks o_MEI and CLAIM. Re-enabling restores both.
//   - Triggers are latched even when ENABLE=0.
//   - Changing EDGE takes effect next cycle. The previous-value flop is always updated.
//   - Async reset mid-claim: all sources return to IDLE, no partial state.
// CONFIGURATION
//  MEI_CTRL_STATS_EN defined:
//   - per-source 8-bit saturating counter of IDLE->PENDING transitions, read at 0x8+k.
//   - a write of any value to 0x8+k clears that counter.
//   - counters reset to 0.
//  MEI_CTRL_STATS_EN undefined: no counter logic; 0x8+k read 0, writes ignored.
// STRUCTURE
//  mei_ctrl_pkg.vh holds:
//   - register offsets MEI_REG_PENDING/ENABLE/EDGE/CLAIM/COMPLETE/STATS_BASE
//   - FSM encodings MEI_IDLE=2'd0, MEI_PENDING=2'd1, MEI_IN_SERVICE=2'd2
//  Sub-module mei_gateway: one instance per source.
//   - contains the synchroniser, edge detect, REARM and FSM.
//   - inputs: claim/complete pulses, edge mode; output: state.
//  Top level holds the register file, the lowest-index claim priority encoder and read mux.
// TESTING
//  1 Reset with i_IRQ_SRC=6'h3F -> o_MEI=0, reads of 0x0/0x1/0x2 return 0.
//  2 ENABLE=6'h04, EDGE=0, raise src2 -> o_MEI=6'h04 after 3 edges;
//    read CLAIM -> 3, o_MEI=0; write COMPLETE=3 with line still high -> PENDING again next cycle.
//  3 EDGE=6'h01, ENABLE=6'h01, pulse src0 twice before COMPLETE -> CLAIM=1;
//    after COMPLETE=1, o_MEI[0]=1 again (REARM); third CLAIM=1 then COMPLETE -> IDLE.
//  4 ENABLE=6'h3F, sources 1 and 4 pending -> CLAIM returns 2, then 5, then 0.
//  5 ENABLE=0, trigger src5 -> PENDING=6'h20, o_MEI=0, CLAIM=0;
//    write ENABLE=6'h20 -> o_MEI=6'h20 next cycle.
//  6 STATS_EN: 300 edge triggers on src1 each completed -> read 0x9 returns 255; write 0x9 -> reads 0.

Source files
------------

// File: rtl/mei_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mei_ctrl_pkg
//   Shared definitions for the machine-external-interrupt controller:
//   register word offsets, bus widths, the per-source FSM state encoding
//   and a small address-decode helper for the optional statistics window.
//   No ports (package).
// ---------------------------------------------------------------------------
package mei_ctrl_pkg;

  localparam int unsigned MEI_ADDR_W = 4;
  localparam int unsigned MEI_DATA_W = 32;

  localparam logic [MEI_ADDR_W-1:0] MEI_REG_PENDING    = 4'h0;
  localparam logic [MEI_ADDR_W-1:0] MEI_REG_ENABLE     = 4'h1;
  localparam logic [MEI_ADDR_W-1:0] MEI_REG_EDGE       = 4'h2;
  localparam logic [MEI_ADDR_W-1:0] MEI_REG_CLAIM      = 4'h3;
  localparam logic [MEI_ADDR_W-1:0] MEI_REG_COMPLETE   = 4'h4;
  localparam logic [MEI_ADDR_W-1:0] MEI_REG_STATS_BASE = 4'h8;

  typedef enum logic [1:0] {
    MEI_IDLE       = 2'd0,
    MEI_PENDING    = 2'd1,
    MEI_IN_SERVICE = 2'd2
  } mei_state_e;

  // True when addr falls in the per-source counter window 0x8 + k, k < n_src.
  function automatic logic is_stats_addr(input logic [MEI_ADDR_W-1:0] addr,
                                         input int n_src);
    return addr[3] && (int'(addr[2:0]) < n_src);
  endfunction

endpackage

// File: rtl/mei_ctrl_if.sv
// ---------------------------------------------------------------------------
// mei_ctrl_if
//   Software register port of the interrupt controller.
//   Signals:
//     i_WE     register write strobe
//     i_RE     register read strobe
//     i_ADDR   register word index (4 bits)
//     i_WDATA  write data (32 bits)
//     o_RDATA  read data, registered in the controller (32 bits)
//   Modports: master (software / bench side), slave (controller side).
// ---------------------------------------------------------------------------
interface mei_ctrl_if;
  import mei_ctrl_pkg::*;

  logic                  i_WE;
  logic                  i_RE;
  logic [MEI_ADDR_W-1:0] i_ADDR;
  logic [MEI_DATA_W-1:0] i_WDATA;
  logic [MEI_DATA_W-1:0] o_RDATA;

  modport master (
    output i_WE, i_RE, i_ADDR, i_WDATA,
    input  o_RDATA
  );

  modport slave (
    input  i_WE, i_RE, i_ADDR, i_WDATA,
    output o_RDATA
  );

endinterface

// File: rtl/mei_gateway.sv
// ---------------------------------------------------------------------------
// mei_gateway
//   One interrupt source: synchronises the raw asynchronous line, detects a
//   level or rising-edge trigger, remembers edges that arrive while the
//   source is already busy (rearm), and runs the IDLE/PENDING/IN_SERVICE FSM.
//   Ports:
//     i_CLK      core clock, rising edge
//     i_RSTn     asynchronous active-low reset
//     irq_raw    raw asynchronous interrupt line, active-high
//     edge_mode  1 = rising-edge trigger, 0 = level trigger
//     claim      one-cycle pulse: a CLAIM read returned this source
//     complete   one-cycle pulse: COMPLETE written with this source's id
//     state      current FSM state
// ---------------------------------------------------------------------------
module mei_gateway
  import mei_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_CLK,
  input  logic       i_RSTn,
  input  logic       irq_raw,
  input  logic       edge_mode,
  input  logic       claim,
  input  logic       complete,
  output mei_state_e state
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;
  logic                   line;
  logic                   rise;
  logic                   trigger;
  logic                   rearm_q;
  logic                   rearm_d;
  mei_state_e             state_q;
  mei_state_e             state_d;

  // NOTE: every clocked process uses non-blocking assignments so all flops
  // sample pre-edge values; blocking here would collapse the sync chain.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], irq_raw};
      // Previous value tracks in both modes so switching to edge mode
      // never sees a stale history.
      sync_prev_q <= line;
    end
  end

  assign line    = sync_q[SYNC_STAGES-1];
  assign rise    = line & ~sync_prev_q;
  assign trigger = edge_mode ? rise : line;

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q <= MEI_IDLE;
      rearm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rearm_q <= rearm_d;
    end
  end

  // NOTE: defaults first so every path assigns both outputs; otherwise the
  // combinational block would infer latches.
  always_comb begin
    state_d = state_q;
    rearm_d = rearm_q;

    unique case (state_q)
      MEI_IDLE:       if (trigger) state_d = MEI_PENDING;
      MEI_PENDING:    if (claim)   state_d = MEI_IN_SERVICE;
      MEI_IN_SERVICE: if (complete) begin
        state_d = (rearm_q || trigger) ? MEI_PENDING : MEI_IDLE;
      end
      default: begin
        state_d = MEI_IDLE;
        rearm_d = 1'b0;
      end
    endcase

    // An edge that lands while the source is busy must not be lost.
    if (edge_mode && rise &&
        (state_q == MEI_PENDING || state_q == MEI_IN_SERVICE)) begin
      rearm_d = 1'b1;
    end

    // Entering PENDING consumes any remembered edge.
    if (state_d == MEI_PENDING && state_q != MEI_PENDING) begin
      rearm_d = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/mei_ctrl.sv
// ---------------------------------------------------------------------------
// mei_ctrl
//   Platform-side external-interrupt controller feeding the CSR block's
//   machine-external-interrupt inputs (o_MEI[k] -> i_MEI_k).
//   Holds the ENABLE/EDGE registers, the lowest-index claim priority
//   encoder, the registered read mux and one mei_gateway per source.
//   Ports:
//     i_CLK      core clock, rising edge
//     i_RSTn     asynchronous active-low reset
//     i_IRQ_SRC  raw asynchronous interrupt lines, active-high [N_SRC]
//     bus        register port (mei_ctrl_if.slave)
//     o_MEI      per-source request: PENDING & ENABLE [N_SRC]
//   Build option: MEI_CTRL_STATS_EN adds per-source 8-bit saturating
//   counters of IDLE->PENDING transitions at 0x8+k (write clears).
// ---------------------------------------------------------------------------
module mei_ctrl
  import mei_ctrl_pkg::*;
#(
  parameter int N_SRC       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_CLK,
  input  logic             i_RSTn,
  input  logic [N_SRC-1:0] i_IRQ_SRC,
  mei_ctrl_if.slave        bus,
  output logic [N_SRC-1:0] o_MEI
);

  localparam int ID_W = $clog2(N_SRC + 1);

  logic [N_SRC-1:0]      enable_q;
  logic [N_SRC-1:0]      edge_q;
  logic [N_SRC-1:0]      pend_vec;
  logic [N_SRC-1:0]      masked;
  logic [N_SRC-1:0]      claim_pulse;
  logic [N_SRC-1:0]      complete_pulse;
  mei_state_e            gw_state [N_SRC];
  logic                  wr_en;
  logic                  rd_en;
  logic                  claim_rd;
  logic                  complete_wr;
  logic [ID_W-1:0]       claim_id;
  logic [MEI_DATA_W-1:0] rd_mux;

  // A read that collides with a write is dropped entirely, including the
  // CLAIM side effect.
  assign wr_en       = bus.i_WE;
  assign rd_en       = bus.i_RE & ~bus.i_WE;
  assign claim_rd    = rd_en && (bus.i_ADDR == MEI_REG_CLAIM);
  assign complete_wr = wr_en && (bus.i_ADDR == MEI_REG_COMPLETE);

  for (genvar k = 0; k < N_SRC; k++) begin : g_src
    mei_gateway #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_gw (
      .i_CLK     (i_CLK),
      .i_RSTn    (i_RSTn),
      .irq_raw   (i_IRQ_SRC[k]),
      .edge_mode (edge_q[k]),
      .claim     (claim_pulse[k]),
      .complete  (complete_pulse[k]),
      .state     (gw_state[k])
    );

    assign pend_vec[k]       = (gw_state[k] == MEI_PENDING);
    // claim_id is only non-zero for an enabled PENDING source, so this
    // pulse never reaches a source in another state.
    assign claim_pulse[k]    = claim_rd && (claim_id == ID_W'(k + 1));
    // Full-width compare: ids with stray upper bits are ignored.
    assign complete_pulse[k] = complete_wr &&
                               (bus.i_WDATA == MEI_DATA_W'(k + 1));
  end

  assign masked = pend_vec & enable_q;
  assign o_MEI  = masked;

  // Lowest index wins: scan downwards so the last hit is the smallest k.
  always_comb begin
    claim_id = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (masked[k]) claim_id = ID_W'(k + 1);
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      enable_q <= '0;
      edge_q   <= '0;
    end else if (wr_en) begin
      case (bus.i_ADDR)
        MEI_REG_ENABLE: enable_q <= bus.i_WDATA[N_SRC-1:0];
        MEI_REG_EDGE:   edge_q   <= bus.i_WDATA[N_SRC-1:0];
        default: ;
      endcase
    end
  end

`ifdef MEI_CTRL_STATS_EN
  logic [7:0]       stat_cnt [N_SRC];
  logic [N_SRC-1:0] was_idle_q;

  // NOTE: the counter array is a handful of flops, not a RAM, so it takes
  // the async reset like any other state.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      was_idle_q <= '0;
      for (int k = 0; k < N_SRC; k++) stat_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < N_SRC; k++) begin
        was_idle_q[k] <= (gw_state[k] == MEI_IDLE);
        // IDLE on the previous cycle and PENDING now is exactly one
        // IDLE->PENDING transition; IN_SERVICE->PENDING is not counted.
        if (wr_en && is_stats_addr(bus.i_ADDR, N_SRC) &&
            (bus.i_ADDR[2:0] == 3'(k))) begin
          stat_cnt[k] <= '0;
        end else if (was_idle_q[k] && pend_vec[k] && (stat_cnt[k] != 8'hFF)) begin
          stat_cnt[k] <= stat_cnt[k] + 8'd1;
        end
      end
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (bus.i_ADDR)
      MEI_REG_PENDING: rd_mux[N_SRC-1:0] = pend_vec;
      MEI_REG_ENABLE:  rd_mux[N_SRC-1:0] = enable_q;
      MEI_REG_EDGE:    rd_mux[N_SRC-1:0] = edge_q;
      MEI_REG_CLAIM:   rd_mux[ID_W-1:0]  = claim_id;
      default: begin
`ifdef MEI_CTRL_STATS_EN
        if (is_stats_addr(bus.i_ADDR, N_SRC)) begin
          rd_mux[7:0] = stat_cnt[bus.i_ADDR[2:0]];
        end
`endif
      end
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      bus.o_RDATA <= '0;
    end else if (rd_en) begin
      bus.o_RDATA <= rd_mux;
    end
  end

endmodule
